// File: rtl/uart_tx_if.sv
// uart_if: parallel-word valid/ready handshake plus the serial line
// shared by the UART transmitter and receiver.
interface uart_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;
   logic                  sig;

   modport tx (
      input  data,
      input  valid,
      output ready,
      output sig
   );

   modport rx (
      output data,
      output valid,
      input  ready,
      input  sig
   );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, start + DATA_WIDTH data bits (LSB first) + stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_RATE  = 115200,
   parameter int CLK_FREQ   = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   uart_if.tx   txif
);
   localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
   localparam int CW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PULSE_WIDTH - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  tick;

   assign tick = (cnt == CNT_LAST);

   // sig follows state one edge later, so the start bit falls
   // one cycle after the acceptance edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         shreg      <= '0;
         txif.sig   <= 1'b1;
         txif.ready <= 1'b0;
      end else begin
         cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
         unique case (state)
            IDLE: begin
               txif.sig   <= 1'b1;
               txif.ready <= 1'b1;
               idx        <= '0;
               if (txif.valid && txif.ready) begin
                  shreg      <= txif.data;
                  txif.ready <= 1'b0;
                  state      <= START;
               end
            end
            START: begin
               txif.sig <= 1'b0;
               if (tick) begin
                  state <= DATA;
               end
            end
            DATA: begin
               txif.sig <= shreg[idx];
               if (tick) begin
                  if (idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               txif.sig <= ^shreg;
               if (tick) begin
                  state <= STOP;
               end
            end
`endif
            STOP: begin
               txif.sig <= 1'b1;
               if (tick) begin
                  txif.ready <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               txif.sig   <= 1'b1;
               txif.ready <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end
endmodule
